filter_window_ctrl: RTL and testbench

Sequencer for the 3x3 pixel filter datapath. It walks every interior pixel of a source image held in a single-port frame memory and fetches the 9 neighbourhood pixels one per cycle. It presents the packed window to the filter with a one-cycle valid strobe, waits the filter's fixed latency, then writes the filter result to a destination memory. It sits between the source/destination frame memories and the filter instance and owns all addressing and frame-level start/done signalling.

---
 rtl/filter_window_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_filter_window_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_window_ctrl.sv
// Sequencer for the 3x3 pixel filter: fetches each interior neighbourhood,
// strobes the window into the filter, and writes the result back.
module filter_window_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        rd_data,
    output logic              win_valid,
    output logic [35:0]       win_pixels,
    input  logic [4:0]        filt_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [4:0]        wr_data
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int LW = $clog2(LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAP,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [3:0]        tap_q, tap_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [35:0]       win_q, win_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              win_valid_q, win_valid_d;
    logic [35:0]       win_pixels_q, win_pixels_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [4:0]        wr_data_q, wr_data_d;
    logic              last_centre;

    function automatic logic [ADDR_W-1:0] tap_addr(
        input logic [3:0]    k,
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        int r;
        int c;
        r = int'(k) / 3;
        c = int'(k) % 3;
        return ADDR_W'((int'(y) + r - 1) * IMG_W + int'(x) + c - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] out_addr(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        return ADDR_W'((int'(y) - 1) * (IMG_W - 2) + int'(x) - 1);
    endfunction

    assign last_centre = (x_q == XW'(IMG_W - 2)) && (y_q == YW'(IMG_H - 2));

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        tap_d        = tap_q;
        lat_d        = lat_q;
        win_d        = win_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_en_d      = rd_en_q;
        rd_addr_d    = rd_addr_q;
        win_valid_d  = 1'b0;
        win_pixels_d = win_pixels_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    x_d       = XW'(1);
                    y_d       = YW'(1);
                    tap_d     = 4'd0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = tap_addr(4'd0, XW'(1), YW'(1));
                end
            end
            S_FETCH: begin
                // first shift of each pixel takes stale data; it falls out by CAP
                win_d = {win_q[31:0], rd_data};
                if (tap_q == 4'd8) begin
                    state_d = S_CAP;
                    rd_en_d = 1'b0;
                end else begin
                    tap_d     = tap_q + 4'd1;
                    rd_addr_d = tap_addr(tap_q + 4'd1, x_q, y_q);
                end
            end
            S_CAP: begin
                win_d        = {win_q[31:0], rd_data};
                win_pixels_d = {win_q[31:0], rd_data};
                win_valid_d  = 1'b1;
                state_d      = S_ISSUE;
            end
            S_ISSUE: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LW'(LAT - 1)) begin
                    wr_data_d = filt_result;
                    wr_addr_d = out_addr(x_q, y_q);
                    wr_en_d   = 1'b1;
                    state_d   = S_WRITE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_WRITE: begin
                if (last_centre) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    if (x_q == XW'(IMG_W - 2)) begin
                        x_d = XW'(1);
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    tap_d     = 4'd0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = tap_addr(4'd0, x_d, y_d);
                    state_d   = S_FETCH;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            tap_q        <= '0;
            lat_q        <= '0;
            win_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            win_valid_q  <= 1'b0;
            win_pixels_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tap_q        <= tap_d;
            lat_q        <= lat_d;
            win_q        <= win_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            win_valid_q  <= win_valid_d;
            win_pixels_q <= win_pixels_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign win_valid  = win_valid_q;
    assign win_pixels = win_pixels_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Directed bench for filter_window_ctrl: 8x8/LAT2, 5x4/LAT1 and 3x3 instances
// with behavioural memories, sum/9 filter models and write scoreboards.
module tb_filter_window_ctrl;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, busy_a, done_a, rd_en_a, win_valid_a, wr_en_a;
    logic [5:0]  rd_addr_a, wr_addr_a;
    logic [3:0]  rd_data_a = '0;
    logic [35:0] win_a;
    logic [4:0]  filt_a, wr_data_a, pa1 = '0, pa2 = '0;

    logic        start_b = 1'b0, busy_b, done_b, rd_en_b, win_valid_b, wr_en_b;
    logic [4:0]  rd_addr_b, wr_addr_b;
    logic [3:0]  rd_data_b = '0;
    logic [35:0] win_b;
    logic [4:0]  filt_b, wr_data_b, pb1 = '0;

    logic        start_c = 1'b0, busy_c, done_c, rd_en_c, win_valid_c, wr_en_c;
    logic [3:0]  rd_addr_c, wr_addr_c;
    logic [3:0]  rd_data_c = '0;
    logic [35:0] win_c;
    logic [4:0]  filt_c, wr_data_c, pc1 = '0, pc2 = '0;

    filter_window_ctrl #(.IMG_W(8), .IMG_H(8), .ADDR_W(6), .LAT(2)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a),
        .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .win_valid(win_valid_a), .win_pixels(win_a),
        .filt_result(filt_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a)
    );

    filter_window_ctrl #(.IMG_W(5), .IMG_H(4), .ADDR_W(5), .LAT(1)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b),
        .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .win_valid(win_valid_b), .win_pixels(win_b),
        .filt_result(filt_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b)
    );

    filter_window_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(4), .LAT(2)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c),
        .done(done_c), .rd_en(rd_en_c), .rd_addr(rd_addr_c),
        .rd_data(rd_data_c), .win_valid(win_valid_c), .win_pixels(win_c),
        .filt_result(filt_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
        .wr_data(wr_data_c)
    );

    // source image: src[i] = i % 16
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= 4'(rd_addr_a);
        if (rd_en_b) rd_data_b <= 4'(rd_addr_b);
        if (rd_en_c) rd_data_c <= 4'(rd_addr_c);
    end

    function automatic logic [4:0] fsum(input logic [35:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) s += int'(w[k*4 +: 4]);
        return 5'(s / 9);
    endfunction

    // filter models; 31 is never a legal result, so off-time sampling shows
    always @(posedge clk) begin
        pa1 <= win_valid_a ? fsum(win_a) : 5'h1f;
        pa2 <= pa1;
        pb1 <= win_valid_b ? fsum(win_b) : 5'h1f;
        pc1 <= win_valid_c ? fsum(win_c) : 5'h1f;
        pc2 <= pc1;
    end
    assign filt_a = pa2;
    assign filt_b = pb1;
    assign filt_c = pc2;

    function automatic logic [35:0] mkwin(input int w, input int x, input int y);
        logic [35:0] v;
        int a;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            a = (y + k / 3 - 1) * w + x + k % 3 - 1;
            v[(8 - k) * 4 +: 4] = 4'(a % 16);
        end
        return v;
    endfunction

    int checks = 0, errors = 0, cyc = 0, st = 0;
    int st_a = 0, st_b = 0, st_c = 0;
    int nwr_a = 0, nwr_b = 0, nwr_c = 0;
    int ndone_a = 0, ndone_b = 0, ndone_c = 0;
    int dcyc_a = -1, dcyc_b = -1, dcyc_c = -1;
    logic busy_prev_a = 1'b0;
    wr_t qa[$], qb[$], qc[$];
    int rda[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input int w, input int h, input int npix);
        int n;
        n = 0;
        for (int y = 1; y <= h - 2; y++) begin
            for (int x = 1; x <= w - 2; x++) begin
                if (n < npix) begin
                    wr_t e;
                    e.addr = (y - 1) * (w - 2) + x - 1;
                    e.data = int'(fsum(mkwin(w, x, y)));
                    case (id)
                        0: qa.push_back(e);
                        1: qb.push_back(e);
                        default: qc.push_back(e);
                    endcase
                    n++;
                end
            end
        end
    endtask

    task automatic mon();
        wr_t e;
        if (wr_en_a) begin
            chk("a_sb_has_entry", 64'(qa.size() > 0), 64'd1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_wr_addr", 64'(wr_addr_a), 64'(e.addr));
                chk("a_wr_data", 64'(wr_data_a), 64'(e.data));
                chk("a_wr_cycle", 64'(cyc), 64'(st_a + 14 * (nwr_a + 1)));
            end
            nwr_a++;
        end
        if (done_a) begin
            ndone_a++;
            dcyc_a = cyc;
            chk("a_busy_low_at_done", 64'(busy_a), 64'd0);
            chk("a_busy_high_before_done", 64'(busy_prev_a), 64'd1);
        end
        busy_prev_a = busy_a;
        if (rd_en_a) rda.push_back(int'(rd_addr_a));
        if (wr_en_b) begin
            chk("b_sb_has_entry", 64'(qb.size() > 0), 64'd1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_wr_addr", 64'(wr_addr_b), 64'(e.addr));
                chk("b_wr_data", 64'(wr_data_b), 64'(e.data));
                chk("b_wr_cycle", 64'(cyc), 64'(st_b + 13 * (nwr_b + 1)));
            end
            nwr_b++;
        end
        if (done_b) begin
            ndone_b++;
            dcyc_b = cyc;
        end
        if (wr_en_c) begin
            chk("c_sb_has_entry", 64'(qc.size() > 0), 64'd1);
            if (qc.size() > 0) begin
                e = qc.pop_front();
                chk("c_wr_addr", 64'(wr_addr_c), 64'(e.addr));
                chk("c_wr_data", 64'(wr_data_c), 64'(e.data));
                chk("c_wr_cycle", 64'(cyc), 64'(st_c + 14 * (nwr_c + 1)));
            end
            nwr_c++;
        end
        if (done_c) begin
            ndone_c++;
            dcyc_c = cyc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    initial begin
        step();
        step();
        chk("a_reset_outs", 64'({busy_a, done_a, rd_en_a, rd_addr_a, win_valid_a,
            win_a, wr_en_a, wr_addr_a, wr_data_a}), 64'd0);
        chk("b_reset_outs", 64'({busy_b, done_b, rd_en_b, rd_addr_b, win_valid_b,
            win_b, wr_en_b, wr_addr_b, wr_data_b}), 64'd0);
        chk("c_reset_outs", 64'({busy_c, done_c, rd_en_c, rd_addr_c, win_valid_c,
            win_c, wr_en_c, wr_addr_c, wr_data_c}), 64'd0);
        reset = 1'b0;
        step();
        step();

        // frame 1 on all three instances
        push_exp(0, 8, 8, 36);
        push_exp(1, 5, 4, 6);
        push_exp(2, 3, 3, 1);
        st = cyc;
        st_a = cyc;
        st_b = cyc;
        st_c = cyc;
        rda.delete();
        chk("a_busy_before_start", 64'(busy_a), 64'd0);
        start_a = 1'b1;
        start_b = 1'b1;
        start_c = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            start_a = 1'b0;
            start_b = 1'b0;
            start_c = 1'b0;
            if (k == 0) chk("a_busy_after_start", 64'(busy_a), 64'd1);
            chk("a_rd_en", 64'(rd_en_a), 64'd1);
            chk("a_rd_addr", 64'(rd_addr_a), 64'((k / 3) * 8 + k % 3));
            chk("b_rd_addr", 64'(rd_addr_b), 64'((k / 3) * 5 + k % 3));
            chk("c_rd_addr", 64'(rd_addr_c), 64'((k / 3) * 3 + k % 3));
        end
        step();
        chk("a_rd_en_cap", 64'(rd_en_a), 64'd0);
        step();
        chk("a_win_valid", 64'(win_valid_a), 64'd1);
        chk("a_win_pixels", 64'(win_a), 64'(mkwin(8, 1, 1)));
        chk("b_win_pixels", 64'(win_b), 64'(mkwin(5, 1, 1)));
        chk("c_win_pixels", 64'(win_c), 64'(mkwin(3, 1, 1)));
        step();
        chk("a_win_valid_pulse", 64'(win_valid_a), 64'd0);
        chk("a_win_hold", 64'(win_a), 64'(mkwin(8, 1, 1)));
        while (cyc < st + 100) step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        while (ndone_a == 0 && cyc < st + 700) step();
        chk("a_done_cycle", 64'(dcyc_a), 64'(st + 505));
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (20) step();
        chk("a_busy_idle", 64'(busy_a), 64'd0);
        chk("a_nwrites", 64'(nwr_a), 64'd36);
        chk("a_sb_empty", 64'(qa.size()), 64'd0);
        chk("a_ndone", 64'(ndone_a), 64'd1);
        chk("a_nreads", 64'(rda.size()), 64'd324);
        if (rda.size() >= 9) begin
            for (int k = 0; k < 9; k++)
                chk("a_last_win_rd", 64'(rda[rda.size() - 9 + k]),
                    64'((5 + k / 3) * 8 + 5 + k % 3));
        end
        chk("b_done_cycle", 64'(dcyc_b), 64'(st + 79));
        chk("b_nwrites", 64'(nwr_b), 64'd6);
        chk("b_sb_empty", 64'(qb.size()), 64'd0);
        chk("b_ndone", 64'(ndone_b), 64'd1);
        chk("c_done_cycle", 64'(dcyc_c), 64'(st + 15));
        chk("c_nwrites", 64'(nwr_c), 64'd1);
        chk("c_sb_empty", 64'(qc.size()), 64'd0);

        // frame 2: reset during the first WAIT cycle of pixel index 9
        nwr_a = 0;
        ndone_a = 0;
        push_exp(0, 8, 8, 9);
        st_a = cyc;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        while (cyc < st_a + 138) step();
        reset = 1'b1;
        #1;
        chk("a_reset_mid_outs", 64'({busy_a, done_a, rd_en_a, rd_addr_a, win_valid_a,
            win_a, wr_en_a, wr_addr_a, wr_data_a}), 64'd0);
        step();
        step();
        reset = 1'b0;
        repeat (40) step();
        chk("a_abort_nwrites", 64'(nwr_a), 64'd9);
        chk("a_abort_sb_empty", 64'(qa.size()), 64'd0);
        chk("a_abort_ndone", 64'(ndone_a), 64'd0);
        chk("a_abort_busy", 64'(busy_a), 64'd0);

        // frame 3: clean restart
        nwr_a = 0;
        dcyc_a = -1;
        push_exp(0, 8, 8, 36);
        st_a = cyc;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("a_restart_rd_en", 64'(rd_en_a), 64'd1);
        chk("a_restart_rd_addr", 64'(rd_addr_a), 64'd0);
        while (ndone_a == 0 && cyc < st_a + 700) step();
        chk("a_restart_done_cycle", 64'(dcyc_a), 64'(st_a + 505));
        repeat (3) step();
        chk("a_restart_nwrites", 64'(nwr_a), 64'd36);
        chk("a_restart_sb_empty", 64'(qa.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
